// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Owns the word-aligned program counter and sequences the fetch/execute
// cycle around the next-address generator:
//   RESET -> FETCH -> EXEC -> FETCH ...  with terminal HALT and FAULT states.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     instruction-memory read request (FETCH only)
//   imem_addr    word address of the read, always equal to pc
//   imem_ack     read complete, qualifies imem_rdata / imem_err
//   imem_rdata   instruction word from memory
//   imem_err     bus error, only meaningful together with imem_ack
//   instr        latched instruction word
//   instr_valid  instr / pc valid for execute (EXEC only)
//   instr_ready  execute finished, nxt_pc valid
//   nxt_pc       next PC from the next-address generator
//   halt         retiring instruction requests a stop
//   pc           PC of the current instruction
//   halted       sticky, set on entry to HALT
//   fault        sticky, set on entry to FAULT
//   cycle_cnt    active-cycle counter (zero unless PC_PERF_CNT_EN)
//   instret_cnt  retired-instruction counter (zero unless PC_PERF_CNT_EN)
//
// Build option
//   PC_PERF_CNT_EN  when defined, cycle_cnt / instret_cnt are live 32-bit
//                   wrapping counters; otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
   parameter logic [29:0] RESET_VECTOR = 30'h0010_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic [29:0] nxt_pc,
   input  logic        halt,
   output logic [29:0] pc,
   output logic        halted,
   output logic        fault,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   state_t state;

   // RESET spends one full clock cycle after release before the first
   // fetch, so the first request appears on the second rising edge.
   // This flag marks that the first post-release edge has been seen.
   logic boot_armed;

   // The read address is the PC itself; pc only changes on the EXEC
   // retire edge, which keeps the address stable across FETCH.
   assign imem_addr = pc;

   // Main sequencer. All outputs are flops updated together with the
   // state, so nothing on the output side depends combinationally on
   // an input. Inputs outside the state that consumes them are ignored
   // simply because no other case arm looks at them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RESET;
         boot_armed  <= 1'b0;
         pc          <= RESET_VECTOR;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         case (state)
            S_RESET: begin
               if (boot_armed) begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
               end else begin
                  boot_armed <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  if (imem_err) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                  end else begin
                     state       <= S_EXEC;
                     instr       <= imem_rdata;
                     instr_valid <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               if (instr_ready) begin
                  pc          <= nxt_pc;
                  instr_valid <= 1'b0;
                  if (halt) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else begin
                     state    <= S_FETCH;
                     imem_req <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_RESET;
            end
         endcase
      end
   end

`ifdef PC_PERF_CNT_EN
   logic [31:0] cycle_q;
   logic [31:0] instret_q;

   // Performance counters. Cycles are counted only while the sequencer
   // is doing work (FETCH or EXEC); an instruction retires on every EXEC
   // edge with instr_ready, including the one that halts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if ((state == S_FETCH) || (state == S_EXEC)) begin
            cycle_q <= cycle_q + 32'd1;
         end
         if ((state == S_EXEC) && instr_ready) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Self-checking bench for pc_fetch_ctrl. The bench plays both instruction
// memory and the execute stage, tracking the expected PC, instruction and
// counter values per transaction, and checks every cycle of each fetch and
// execute phase. Works with and without PC_PERF_CNT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

   localparam logic [29:0] RV = 30'h0010_0000;
`ifdef PC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [29:0] nxt_pc;
   logic        halt;
   logic [29:0] pc;
   logic        halted;
   logic        fault;
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;

   int          tests_run;
   int          tests_failed;

   logic [29:0] exp_pc;
   logic [31:0] exp_instr;
   logic [31:0] exp_cyc;
   logic [31:0] exp_ret;

   pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .nxt_pc      (nxt_pc),
      .halt        (halt),
      .pc          (pc),
      .halted      (halted),
      .fault       (fault),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends on its own.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, ".cycle_cnt"},   cycle_cnt,   PERF ? exp_cyc : 32'd0);
      checkOutput({tag, ".instret_cnt"}, instret_cnt, PERF ? exp_ret : 32'd0);
   endtask

   // Hold reset, check the reset values, then release and check that the
   // first request arrives on the second edge after release.
   task automatic doReset();
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      imem_err    = 1'b0;
      instr_ready = 1'b0;
      nxt_pc      = '0;
      halt        = 1'b0;
      exp_pc      = RV;
      exp_instr   = '0;
      exp_cyc     = '0;
      exp_ret     = '0;
      repeat (3) tick();
      checkOutput("rst.imem_req", imem_req, 0);
      checkOutput("rst.pc", pc, RV);
      checkOutput("rst.instr", instr, 0);
      checkOutput("rst.instr_valid", instr_valid, 0);
      checkOutput("rst.halted", halted, 0);
      checkOutput("rst.fault", fault, 0);
      checkCounters("rst");
      rst_n = 1'b1;
      tick();
      checkOutput("boot.req_edge1", imem_req, 0);
      tick();
      checkOutput("boot.req_edge2", imem_req, 1);
      checkOutput("boot.addr", imem_addr, RV);
   endtask

   // One complete instruction: fetch with fwait wait states, execute with
   // ewait cycles of backpressure, then retire with nxt / h. Junk is driven
   // on inputs that must be ignored in each phase.
   task automatic applyStimulus(input int fwait, input logic [31:0] data,
                                input int ewait, input logic [29:0] nxt, input logic h);
      for (int i = 0; i <= fwait; i++) begin
         checkOutput("fetch.req", imem_req, 1);
         checkOutput("fetch.addr", imem_addr, exp_pc);
         checkOutput("fetch.valid", instr_valid, 0);
         instr_ready = 1'($urandom);
         halt        = 1'($urandom);
         nxt_pc      = 30'($urandom);
         imem_err    = (i == fwait) ? 1'b0 : 1'($urandom);
         imem_rdata  = (i == fwait) ? data : $urandom;
         imem_ack    = (i == fwait);
         tick();
         exp_cyc++;
      end
      imem_ack  = 1'b0;
      exp_instr = data;
      for (int i = 0; i <= ewait; i++) begin
         checkOutput("exec.valid", instr_valid, 1);
         checkOutput("exec.req", imem_req, 0);
         checkOutput("exec.instr", instr, exp_instr);
         checkOutput("exec.pc", pc, exp_pc);
         imem_ack    = 1'($urandom);
         imem_err    = 1'($urandom);
         imem_rdata  = $urandom;
         instr_ready = (i == ewait);
         halt        = (i == ewait) ? h : 1'($urandom);
         nxt_pc      = (i == ewait) ? nxt : 30'($urandom);
         tick();
         exp_cyc++;
      end
      exp_ret++;
      exp_pc      = nxt;
      instr_ready = 1'b0;
      halt        = 1'b0;
      imem_ack    = 1'b0;
      imem_err    = 1'b0;
      checkOutput("retire.valid", instr_valid, 0);
      checkOutput("retire.pc", pc, exp_pc);
      checkOutput("retire.req", imem_req, !h);
      checkOutput("retire.halted", halted, h);
      checkCounters("retire");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Boot with a zero-wait fetch.
      doReset();
      applyStimulus(0, 32'hDEAD_BEEF, 0, RV + 30'd1, 1'b0);

      // Sequential flow, one instruction every two cycles.
      applyStimulus(0, 32'h0000_0001, 0, RV + 30'd2, 1'b0);
      applyStimulus(0, 32'h0000_0002, 0, RV + 30'd3, 1'b0);

      // Wait states and backpressure.
      applyStimulus(3, 32'hA5A5_5A5A, 2, RV + 30'd4, 1'b0);

      // Branch redirect from 0x100004, then wrap through the top of memory.
      applyStimulus(1, 32'h1234_5678, 1, 30'h00F_FFF0, 1'b0);
      applyStimulus(0, 32'h0BAD_F00D, 0, 30'h3FFF_FFFF, 1'b0);
      applyStimulus(2, 32'hCAFE_0001, 0, 30'h000_0000, 1'b0);

      // Randomised instruction stream.
      for (int n = 0; n < 16; n++) begin
         applyStimulus($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                       30'($urandom), 1'b0);
      end

      // Halt; the machine must stay stopped despite spurious acks.
      applyStimulus(1, 32'h0000_0073, 1, 30'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) begin
         imem_ack    = 1'($urandom);
         instr_ready = 1'($urandom);
         tick();
         checkOutput("halt.req", imem_req, 0);
         checkOutput("halt.halted", halted, 1);
         checkOutput("halt.pc", pc, exp_pc);
         checkCounters("halt");
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b0;

      // Reset asserted during a fetch wait drops the request at once.
      doReset();
      applyStimulus(0, 32'h1111_2222, 0, RV + 30'd7, 1'b0);
      tick();
      exp_cyc++;
      tick();
      exp_cyc++;
      checkOutput("midrst.req_before", imem_req, 1);
      rst_n = 1'b0;
      #1;
      exp_pc  = RV;
      exp_cyc = '0;
      exp_ret = '0;
      checkOutput("midrst.req", imem_req, 0);
      checkOutput("midrst.pc", pc, RV);
      checkOutput("midrst.instr", instr, 0);
      checkCounters("midrst");

      // Fault path: an errored ack stops the machine without executing.
      doReset();
      applyStimulus(0, 32'h3333_4444, 0, RV + 30'd1, 1'b0);
      checkOutput("fault.pre", imem_req, 1);
      imem_rdata = 32'hFFFF_FFFF;
      imem_err   = 1'b1;
      imem_ack   = 1'b1;
      tick();
      exp_cyc++;
      for (int i = 0; i < 4; i++) begin
         imem_ack    = 1'($urandom);
         imem_err    = 1'($urandom);
         instr_ready = 1'($urandom);
         checkOutput("fault.fault", fault, 1);
         checkOutput("fault.valid", instr_valid, 0);
         checkOutput("fault.req", imem_req, 0);
         checkOutput("fault.instr", instr, exp_instr);
         checkOutput("fault.halted", halted, 0);
         checkCounters("fault");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
